// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory port bundle for the load/store unit.
// slave = the LSU itself; master = the execute stage plus data memory around it.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  mem_WE;
    logic [ADDR_WIDTH-1:0] mem_A;
    logic [31:0]           mem_WD;
    logic [31:0]           mem_RD;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_A, mem_WD
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_A, mem_WD
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide memory without byte enables.
// One request in flight; sub-word stores are done as read-merge-write.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          illegal, misaligned;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_ext, merged;
    logic [AW-1:0] word_addr;

    assign word_addr = {addr_q[AW-1:2], 2'b00};

    always_comb begin : decode
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.req_we) begin
            illegal = (bus.req_funct3 > 3'd2);
        end else begin
            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11);
        end
        if (CHECK_ALIGN) begin
            case (bus.req_funct3[1:0])
                2'd1:    misaligned = bus.req_addr[0];
                2'd2:    misaligned = |bus.req_addr[1:0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin : lanes
        rd_byte = bus.mem_RD[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        case (f3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'd0, rd_byte};
            3'd5:    load_ext = {16'd0, rd_half};
            default: load_ext = bus.mem_RD;
        endcase
        merged = bus.mem_RD;
        if (f3_q[1:0] == 2'd0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin : fsm
        state_d        = state_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wr_d           = wr_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        bus.mem_WE     = 1'b0;
        bus.mem_A      = '0;
        bus.mem_WD     = 32'd0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata[15:0];
                    wr_d    = bus.req_wdata;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3 == 3'd2) begin
                        state_d = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                bus.mem_A = word_addr;
                rdata_d   = load_ext;
                state_d   = RESP;
            end
            MERGE: begin
                bus.mem_A = word_addr;
                wr_d      = merged;
                state_d   = WRITE;
            end
            WRITE: begin
                bus.mem_A  = word_addr;
                bus.mem_WE = 1'b1;
                bus.mem_WD = wr_q;
                state_d    = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                rdata_d        = 32'd0;
                err_d          = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset kills any memory side effect and response in the same cycle.
        if (rst) begin
            bus.mem_WE     = 1'b0;
            bus.mem_A      = '0;
            bus.mem_WD     = 32'd0;
            bus.resp_valid = 1'b0;
            bus.resp_rdata = 32'd0;
            bus.resp_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 16'd0;
            wr_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a small word memory model plus a queue of expected responses.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] wd;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:63];

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_RD = mem[bus.mem_A[7:2]];
    always @(posedge clk) begin
        if (bus.mem_WE) mem[bus.mem_A[7:2]] <= bus.mem_WD;
    end

    // Issue one request and watch until its response (bounded); no checking here.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic err, output logic we_seen, output logic [31:0] a_seen,
                           output logic [31:0] wd_seen);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1; rd = 32'd0; err = 1'b0; we_seen = 1'b0; a_seen = 32'd0; wd_seen = 32'd0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.mem_WE) begin
                we_seen = 1'b1; a_seen = bus.mem_A; wd_seen = bus.mem_WD;
            end
            if (bus.resp_valid) begin
                lat = n; rd = bus.resp_rdata; err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_WE !== 1'b0 || bus.mem_A !== 32'd0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b A=%h rv=%b required 0 0 0 0",
                     bus.req_ready, bus.mem_WE, bus.mem_A, bus.resp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b rdata=%h err=%b required 1 0 0",
                     bus.req_ready, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        sb_q.push_back('{rd: 32'd0, err: 1'b0, wd: 32'hDEADBEEF, lat: 32'd2});
        run_txn(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, lat, rd, err, wes, a, wd);
        e = sb_q.pop_front();
        checks++;
        if (32'(lat) !== e.lat || rd !== e.rd || err !== e.err) begin
            errors++;
            $display("FAIL sw_resp: got lat=%0d rdata=%h err=%b required %0d %h %b", lat, rd, err, e.lat, e.rd, e.err);
        end
        checks++;
        if (wes !== 1'b1 || a !== 32'h8 || wd !== e.wd) begin
            errors++;
            $display("FAIL sw_write: got we=%b A=%h WD=%h required 1 00000008 %h", wes, a, wd, e.wd);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] adrs [5] = '{32'h9, 32'h9, 32'hA, 32'h8, 32'h8};
        logic [31:0] exps [5] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEADBEEF};
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{rd: exps[i], err: 1'b0, wd: 32'd0, lat: 32'd2});
            run_txn(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, err, wes, a, wd);
            e = sb_q.pop_front();
            checks++;
            if (32'(lat) !== e.lat || rd !== e.rd || err !== e.err || wes !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d: got lat=%0d rdata=%h err=%b we=%b required %0d %h %b 0",
                         i, lat, rd, err, wes, e.lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_subword_stores();
        logic [2:0]  f3s  [2] = '{3'd0, 3'd1};
        logic [31:0] adrs [2] = '{32'hB, 32'h8};
        logic [31:0] wds  [2] = '{32'h12, 32'hCAFE};
        logic [31:0] exps [2] = '{32'h12ADBEEF, 32'h12ADCAFE};
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{rd: 32'd0, err: 1'b0, wd: exps[i], lat: 32'd3});
            run_txn(1'b1, f3s[i], adrs[i], wds[i], lat, rd, err, wes, a, wd);
            e = sb_q.pop_front();
            checks++;
            if (32'(lat) !== e.lat || rd !== e.rd || err !== e.err) begin
                errors++;
                $display("FAIL subword_resp_%0d: got lat=%0d rdata=%h err=%b required %0d %h %b", i, lat, rd, err, e.lat, e.rd, e.err);
            end
            checks++;
            if (wes !== 1'b1 || a !== 32'h8 || wd !== e.wd) begin
                errors++;
                $display("FAIL subword_write_%0d: got we=%b A=%h WD=%h required 1 00000008 %h", i, wes, a, wd, e.wd);
            end
        end
    endtask

    task automatic test_errors();
        logic        wes_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s   [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [31:0] adrs  [4] = '{32'h6, 32'h3, 32'h8, 32'h8};
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{rd: 32'd0, err: 1'b1, wd: 32'd0, lat: 32'd1});
            run_txn(wes_t[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, rd, err, wes, a, wd);
            e = sb_q.pop_front();
            checks++;
            if (32'(lat) !== e.lat || rd !== e.rd || err !== e.err || wes !== 1'b0) begin
                errors++;
                $display("FAIL error_%0d: got lat=%0d rdata=%h err=%b we=%b required %0d %h %b 0",
                         i, lat, rd, err, wes, e.lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        logic resp_seen;
        run_txn(1'b1, 3'd2, 32'h4, 32'h11111111, lat, rd, err, wes, a, wd);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h55555555;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_WE !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_write: got we=%b required 1", bus.mem_WE);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_WE !== 1'b0 || bus.mem_A !== 32'd0) begin
            errors++;
            $display("FAIL abort_gate: got we=%b A=%h required 0 00000000", bus.mem_WE, bus.mem_A);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b required 1", bus.req_ready);
        end
        resp_seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen = 1'b1;
        end
        checks++;
        if (resp_seen !== 1'b0 || mem[1] !== 32'h11111111) begin
            errors++;
            $display("FAIL abort_effects: got resp_seen=%b mem4=%h required 0 11111111", resp_seen, mem[1]);
        end
        sb_q.push_back('{rd: 32'h11111111, err: 1'b0, wd: 32'd0, lat: 32'd2});
        run_txn(1'b0, 3'd2, 32'h4, 32'h0, lat, rd, err, wes, a, wd);
        e = sb_q.pop_front();
        checks++;
        if (32'(lat) !== e.lat || rd !== e.rd || err !== e.err) begin
            errors++;
            $display("FAIL abort_readback: got lat=%0d rdata=%h err=%b required %0d %h %b", lat, rd, err, e.lat, e.rd, e.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
        int lat; logic [31:0] rd, a, wd; logic err, wes; exp_t e;
        int k, got, viol, last_resp, cyc;
        logic busy;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 3'd2, adrs[i], 32'hA0000000 + 32'(i), lat, rd, err, wes, a, wd);
            sb_q.push_back('{rd: 32'hA0000000 + 32'(i), err: 1'b0, wd: 32'd0, lat: 32'd2});
        end
        k = 0; got = 0; viol = 0; last_resp = -10; busy = 1'b0; cyc = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = adrs[0];
        while (got < 4 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            if (bus.resp_valid) begin
                if (bus.req_ready || sb_q.size() == 0) viol++;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (bus.resp_rdata !== e.rd || bus.resp_err !== e.err) begin
                        errors++;
                        $display("FAIL b2b_data_%0d: got rdata=%h err=%b required %h %b", got, bus.resp_rdata, bus.resp_err, e.rd, e.err);
                    end
                end
                got++; busy = 1'b0; last_resp = cyc;
            end else if (bus.req_ready && bus.req_valid) begin
                if (busy || (k > 0 && cyc != last_resp + 1)) viol++;
                k++; busy = 1'b1;
            end else if (busy && bus.req_ready) begin
                viol++;
            end
            @(posedge clk);
            #1;
            if (k < 4) bus.req_addr = adrs[k];
            else bus.req_valid = 1'b0;
            cyc++;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (got !== 4 || k !== 4 || viol !== 0) begin
            errors++;
            $display("FAIL b2b_flow: got resps=%0d accepts=%0d violations=%0d required 4 4 0", got, k, viol);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_store_word();
        test_loads();
        test_subword_stores();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface: accepts core load/store requests and drives the data memory's clk/WE/A/WD/RD port.
- Handles RV32I byte/halfword/word sizing, sign/zero extension, alignment checks and read-modify-write for sub-word stores. The memory has no byte enables.
- Sits between the execute stage and data_memory.
- Memory reads are combinational (RD follows A); memory writes occur on posedge clk when WE=1.

Parameters:
ADDR_WIDTH, 32, width of req_addr and mem_A
CHECK_ALIGN, 1, 1 = misaligned accesses return an error with no memory access; 0 = low address bits ignored for halfword/word accesses

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE with rst=0; transfer = req_valid & req_ready at posedge
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; misaligned or illegal funct3
mem_WE  output  1  memory write enable
mem_A  output  ADDR_WIDTH  word-aligned byte address, bits[1:0]=00
mem_WD  output  32  memory write data
mem_RD  input  32  memory read data, combinational from mem_A

Behaviour:
- States: IDLE, LOAD, MERGE, WRITE, RESP. All registered outputs reset to 0; state resets to IDLE.
- IDLE: req_ready=1. On transfer, latch we/funct3/addr/wdata, then go to:
  - RESP with err=1 if funct3 is illegal (load 3/6/7; store >2), or CHECK_ALIGN=1 and misaligned (H: addr[0]=1; W: addr[1:0]!=0);
  - LOAD for loads;
  - WRITE for SW, with the write register set to wdata;
  - MERGE for SB/SH.
- LOAD: mem_A={addr[hi:2],00}, mem_WE=0. At posedge:
  - select the byte lane addr[1:0] or the halfword lane addr[1];
  - sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW;
  - register into resp_rdata, then go to RESP.
- MERGE: mem_A as in LOAD, mem_WE=0. At posedge, replace lane bytes of mem_RD with wdata[7:0] (SB) or wdata[15:0] (SH); other bytes are preserved. Store result in the write register, then go to WRITE.
- WRITE: mem_WE=1, mem_A as above, mem_WD=write register. Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then go to IDLE.
- Latency, counted as posedges after the accept edge until the edge ending resp_valid high:
  - loads and SW: resp_valid high during cycle 2;
  - SB/SH: cycle 3;
  - errors: cycle 1.
- Throughput: one request in flight; req_ready=0 in every non-IDLE state. Back-to-back: a new request may be accepted on the edge leaving RESP→IDLE+1, i.e. the first IDLE cycle.
- mem_A=0, mem_WD=0, mem_WE=0 in IDLE, RESP and during rst.
- mem_WE is gated by !rst combinationally, so a rst asserted during WRITE suppresses the write at that edge.
- Reset mid-operation: abort to IDLE, no resp_valid for the aborted request, latched data discarded.
- resp_rdata/resp_err are held only while resp_valid=1; they are 0 otherwise.
- Address wrap: none; the upper address bits pass through unchanged.
- CHECK_ALIGN=0: misaligned H/W uses addr[1] / ignores addr[1:0] respectively.

Test Plan:
- Reset, then SW addr=0x8 wdata=0xDEADBEEF → WRITE cycle shows mem_WE=1 mem_A=0x8 mem_WD=0xDEADBEEF; resp_valid on 2nd cycle, rdata=0, err=0.
- After memory[0x8]=0xDEADBEEF:
  - LB addr=0x9 → 0xFFFFFFBE;
  - LBU 0x9 → 0x000000BE;
  - LH 0xA → 0xFFFFDEAD;
  - LHU 0x8 → 0x0000BEEF;
  - LW 0x8 → 0xDEADBEEF;
  - each with resp_valid on cycle 2, and mem_WE=0 throughout.
- SB addr=0xB wdata=0x12 over 0xDEADBEEF → WRITE cycle mem_WD=0x12ADBEEF. SH addr=0x8 wdata=0xCAFE → mem_WD=0x12ADCAFE. resp_valid on cycle 3.
- Error cases, each giving resp_valid on cycle 1 with err=1 and mem_WE never asserted:
  - LW addr=0x6;
  - SH addr=0x3;
  - load funct3=3;
  - store funct3=4.
- Assert rst during the WRITE cycle of an SW to 0x4 → mem_WE low, memory[0x4] unchanged, no resp_valid. req_ready=1 the first cycle after rst deasserts.
- Hold req_valid=1 with four back-to-back LW requests → exactly one accept per IDLE visit, req_ready=0 while busy, four resp_valid pulses in order.
